// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: exception/ERET redirect controller.
// Flushes IF/ID/EX on an exception or ERET and drains stale fetch responses.
// It then hands the redirect PC to IF over a valid/ready handshake.
// It also tracks how many fetch requests are in flight.
// Optional feature macro: FLUSH_CNT_EN adds a 32-bit count of accepted flushes.
module exc_redirect_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          MAX_OUTST  = 4,
    parameter int          CNT_W      = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [31:0]      epc,
    input  logic             inst_req_fire,
    input  logic             inst_data_ok,
    input  logic             redirect_ready,
`ifdef FLUSH_CNT_EN
    output logic [31:0]      flush_cnt,
`endif
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             discard_resp,
    output logic             busy,
    output logic             outst_full,
    output logic [CNT_W-1:0] outst_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] outst_cnt_q, outst_cnt_d;
    logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             req_any;

    assign req_any = exc_valid | eret_valid;

    // Outstanding-fetch counter: +fire -data_ok, held at its bounds so a protocol slip cannot wrap it
    always_comb begin
        outst_cnt_d = outst_cnt_q;
        if (inst_req_fire && !inst_data_ok && (outst_cnt_q != CNT_MAX)) begin
            outst_cnt_d = outst_cnt_q + CNT_ONE;
        end else if (inst_data_ok && !inst_req_fire && (outst_cnt_q != CNT_ZERO)) begin
            outst_cnt_d = outst_cnt_q - CNT_ONE;
        end
    end

    // FSM next-state, redirect target capture and stale-response bookkeeping
    always_comb begin
        state_d       = state_q;
        stale_cnt_d   = stale_cnt_q;
        redirect_pc_d = redirect_pc_q;
        flush         = 1'b0;
        discard_resp  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    flush         = 1'b1;
                    // Exception has priority over a simultaneous ERET
                    redirect_pc_d = exc_valid ? EXC_VECTOR : epc;
                    // Everything in flight after this edge, including a fire in
                    // the request cycle itself, belongs to the flushed path
                    stale_cnt_d   = outst_cnt_d;
                    state_d       = (outst_cnt_d == CNT_ZERO) ? ST_REDIR : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // New exception/ERET requests are ignored: the pipeline is already flushed
                if (inst_data_ok) begin
                    discard_resp = 1'b1;
                    if (stale_cnt_q != CNT_ZERO) begin
                        stale_cnt_d = stale_cnt_q - CNT_ONE;
                    end
                    if (stale_cnt_q <= CNT_ONE) begin
                        state_d = ST_REDIR;
                    end
                end
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            outst_cnt_q   <= '0;
            stale_cnt_q   <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            outst_cnt_q   <= outst_cnt_d;
            stale_cnt_q   <= stale_cnt_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

`ifdef FLUSH_CNT_EN
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Count of accepted flush requests, wrapping at 2^32
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if ((state_q == ST_IDLE) && req_any) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Flush counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_cnt = flush_cnt_q;
`endif

    assign redirect_valid = (state_q == ST_REDIR);
    assign busy           = (state_q != ST_IDLE);
    assign redirect_pc    = redirect_pc_q;
    assign outst_cnt      = outst_cnt_q;
    assign outst_full     = (outst_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed testbench for exc_redirect_ctrl (FLUSH_CNT_EN build also covered when defined).
module tb_exc_redirect_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_valid, eret_valid, inst_req_fire, inst_data_ok, redirect_ready;
    logic [31:0] epc;
    logic        flush, redirect_valid, discard_resp, busy, outst_full;
    logic [31:0] redirect_pc;
    logic [2:0]  outst_cnt;
`ifdef FLUSH_CNT_EN
    logic [31:0] flush_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    exc_redirect_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .exc_valid      (exc_valid),
        .eret_valid     (eret_valid),
        .epc            (epc),
        .inst_req_fire  (inst_req_fire),
        .inst_data_ok   (inst_data_ok),
        .redirect_ready (redirect_ready),
`ifdef FLUSH_CNT_EN
        .flush_cnt      (flush_cnt),
`endif
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .discard_resp   (discard_resp),
        .busy           (busy),
        .outst_full     (outst_full),
        .outst_cnt      (outst_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid = 0; eret_valid = 0; inst_req_fire = 0; inst_data_ok = 0; redirect_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        epc = 32'h0;
        resetn = 0;
        #12;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy got %b exp 0", busy); end
        vec_cnt++; if (redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rvalid got %b exp 0", redirect_valid); end
        vec_cnt++; if (redirect_pc !== 32'h0) begin err_cnt++; $display("FAIL rst_pc got %h exp 0", redirect_pc); end
        vec_cnt++; if (outst_cnt !== 3'd0 || outst_full !== 1'b0) begin err_cnt++; $display("FAIL rst_cnt got %0d/%b exp 0/0", outst_cnt, outst_full); end
        vec_cnt++; if (flush !== 1'b0 || discard_resp !== 1'b0) begin err_cnt++; $display("FAIL rst_flush_disc got %b/%b exp 0/0", flush, discard_resp); end
        resetn = 1;
        tick();
    endtask

    task automatic test_exc_idle();
        exc_valid = 1;
        #1;
        vec_cnt++; if (flush !== 1'b1) begin err_cnt++; $display("FAIL exc_flush got %b exp 1", flush); end
        tick();
        exc_valid = 0;
        vec_cnt++; if (redirect_valid !== 1'b1) begin err_cnt++; $display("FAIL exc_rvalid got %b exp 1", redirect_valid); end
        vec_cnt++; if (redirect_pc !== VEC) begin err_cnt++; $display("FAIL exc_pc got %h exp %h", redirect_pc, VEC); end
        vec_cnt++; if (busy !== 1'b1 || flush !== 1'b0) begin err_cnt++; $display("FAIL exc_busy_flush got %b/%b exp 1/0", busy, flush); end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        vec_cnt++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL exc_done got %b/%b exp 0/0", busy, redirect_valid); end
    endtask

    task automatic test_eret_drain();
        inst_req_fire = 1;
        tick();
        tick();
        inst_req_fire = 0;
        vec_cnt++; if (outst_cnt !== 3'd2) begin err_cnt++; $display("FAIL drain_cnt got %0d exp 2", outst_cnt); end
        eret_valid = 1; epc = 32'h8000_1234;
        #1;
        vec_cnt++; if (flush !== 1'b1) begin err_cnt++; $display("FAIL eret_flush got %b exp 1", flush); end
        tick();
        eret_valid = 0;
        vec_cnt++; if (busy !== 1'b1 || redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_state got %b/%b exp 1/0", busy, redirect_valid); end
        tick();
        vec_cnt++; if (redirect_valid !== 1'b0 || discard_resp !== 1'b0) begin err_cnt++; $display("FAIL drain_wait got %b/%b exp 0/0", redirect_valid, discard_resp); end
        for (int i = 0; i < 2; i++) begin
            inst_data_ok = 1;
            #1;
            vec_cnt++; if (discard_resp !== 1'b1) begin err_cnt++; $display("FAIL drain_disc%0d got %b exp 1", i, discard_resp); end
            tick();
            inst_data_ok = 0;
            if (i == 0) begin
                vec_cnt++; if (redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_early got %b exp 0", redirect_valid); end
            end
        end
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_1234) begin err_cnt++; $display("FAIL drain_redir got %b/%h exp 1/80001234", redirect_valid, redirect_pc); end
        vec_cnt++; if (outst_cnt !== 3'd0 || discard_resp !== 1'b0) begin err_cnt++; $display("FAIL drain_after got %0d/%b exp 0/0", outst_cnt, discard_resp); end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL drain_done got %b exp 0", busy); end
    endtask

    task automatic test_priority();
        exc_valid = 1; eret_valid = 1; epc = 32'h8000_0010;
        tick();
        exc_valid = 0; eret_valid = 0;
        vec_cnt++; if (redirect_pc !== VEC || redirect_valid !== 1'b1) begin err_cnt++; $display("FAIL prio_pc got %h/%b exp %h/1", redirect_pc, redirect_valid, VEC); end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
    endtask

    task automatic test_fire_in_req();
        inst_req_fire = 1;
        tick();
        inst_req_fire = 1; exc_valid = 1;
        tick();
        inst_req_fire = 0; exc_valid = 0;
        vec_cnt++; if (busy !== 1'b1 || redirect_valid !== 1'b0 || outst_cnt !== 3'd2) begin err_cnt++; $display("FAIL fire_state got %b/%b/%0d exp 1/0/2", busy, redirect_valid, outst_cnt); end
        inst_data_ok = 1;
        #1;
        vec_cnt++; if (discard_resp !== 1'b1) begin err_cnt++; $display("FAIL fire_disc0 got %b exp 1", discard_resp); end
        tick();
        vec_cnt++; if (redirect_valid !== 1'b0 || discard_resp !== 1'b1) begin err_cnt++; $display("FAIL fire_disc1 got %b/%b exp 0/1", redirect_valid, discard_resp); end
        tick();
        inst_data_ok = 0;
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== VEC || outst_cnt !== 3'd0) begin err_cnt++; $display("FAIL fire_redir got %b/%h/%0d exp 1/%h/0", redirect_valid, redirect_pc, outst_cnt, VEC); end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
    endtask

    task automatic test_hold();
        eret_valid = 1; epc = 32'h8000_4444;
        tick();
        eret_valid = 0; epc = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            exc_valid = (i == 2);
            #1;
            vec_cnt++; if (flush !== 1'b0) begin err_cnt++; $display("FAIL hold_flush%0d got %b exp 0", i, flush); end
            vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_4444) begin err_cnt++; $display("FAIL hold_pc%0d got %b/%h exp 1/80004444", i, redirect_valid, redirect_pc); end
            tick();
        end
        exc_valid = 0;
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        vec_cnt++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL hold_done got %b/%b exp 0/0", busy, redirect_valid); end
    endtask

    task automatic test_counter_bounds();
        inst_req_fire = 1;
        for (int i = 0; i < 4; i++) tick();
        inst_req_fire = 0;
        vec_cnt++; if (outst_cnt !== 3'd4 || outst_full !== 1'b1) begin err_cnt++; $display("FAIL full got %0d/%b exp 4/1", outst_cnt, outst_full); end
        inst_data_ok = 1;
        tick();
        tick();
        inst_data_ok = 0;
        vec_cnt++; if (outst_cnt !== 3'd2 || outst_full !== 1'b0) begin err_cnt++; $display("FAIL dec got %0d/%b exp 2/0", outst_cnt, outst_full); end
        inst_req_fire = 1; inst_data_ok = 1;
        tick();
        inst_req_fire = 0; inst_data_ok = 0;
        vec_cnt++; if (outst_cnt !== 3'd2) begin err_cnt++; $display("FAIL same_cycle got %0d exp 2", outst_cnt); end
        vec_cnt++; if (discard_resp !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL idle_disc got %b/%b exp 0/0", discard_resp, busy); end
        inst_data_ok = 1;
        tick();
        tick();
        inst_data_ok = 0;
        vec_cnt++; if (outst_cnt !== 3'd0) begin err_cnt++; $display("FAIL empty got %0d exp 0", outst_cnt); end
    endtask

    task automatic test_reset_mid();
        inst_req_fire = 1;
        tick();
        inst_req_fire = 0; eret_valid = 1; epc = 32'h8000_7777;
        tick();
        eret_valid = 0;
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL mid_busy got %b exp 1", busy); end
        resetn = 0;
        #1;
        vec_cnt++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || outst_cnt !== 3'd0) begin err_cnt++; $display("FAIL mid_rst got %b/%b/%0d exp 0/0/0", busy, redirect_valid, outst_cnt); end
        vec_cnt++; if (redirect_pc !== 32'h0 || discard_resp !== 1'b0 || flush !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_pc got %h/%b/%b exp 0/0/0", redirect_pc, discard_resp, flush); end
`ifdef FLUSH_CNT_EN
        vec_cnt++; if (flush_cnt !== 32'd0) begin err_cnt++; $display("FAIL mid_rst_fcnt got %0d exp 0", flush_cnt); end
`endif
        #2;
        resetn = 1;
        tick();
    endtask

`ifdef FLUSH_CNT_EN
    task automatic test_flush_cnt();
        for (int i = 0; i < 3; i++) begin
            exc_valid = 1;
            tick();
            exc_valid = (i == 1);
            redirect_ready = 1;
            tick();
            exc_valid = 0; redirect_ready = 0;
        end
        vec_cnt++; if (flush_cnt !== 32'd3) begin err_cnt++; $display("FAIL flush_cnt got %0d exp 3", flush_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_exc_idle();
        test_eret_drain();
        test_priority();
        test_fire_in_req();
        test_hold();
        test_counter_bounds();
        test_reset_mid();
`ifdef FLUSH_CNT_EN
        test_flush_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
